ram512_loader: RTL and testbench

- Sequential write-master that fills the 512-word data RAM from a byte stream, e.g. the UART receiver, so programs and data load over serial without resynthesis.
- Takes 8-bit bytes over a valid/ready handshake and packs pairs into 16-bit words, high byte first.
- Drives the RAM's in/address/load port directly; sits immediately upstream of the ram512 block.

---
 rtl/ram512_loader.sv | 161 ++++++++++++++++
 tb/tb_ram512_loader.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram512_loader.sv
// ram512_loader: write master that fills the 512-word data RAM from a byte stream.
// Bytes arrive over rx_valid/rx_ready and are packed in pairs, high byte first.
// Each pair becomes one 16-bit RAM write at consecutive addresses from base_addr.
// Build option RAM512_LOADER_VERIFY_EN reads each word back after writing it.
// On a mismatch the load aborts and a sticky error flag is raised.
module ram512_loader #(
  parameter int ADDR_W = 9,
  parameter int CNT_W  = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]  word_count,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic [15:0]       ram_in,
  output logic [ADDR_W-1:0] ram_address,
  output logic              ram_load,
  input  logic [15:0]       ram_out,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  words_written
);

  localparam logic [CNT_W-1:0]  MAX_WORDS = CNT_W'(2 ** ADDR_W);
  localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
  localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HI,
    ST_LO,
    ST_WR,
    ST_VFY,
    ST_ADV,
    ST_FIN
  } state_t;

  state_t state_reg, state_next;

  logic [CNT_W-1:0]  remaining_reg;
  logic [CNT_W-1:0]  words_written_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [15:0]       data_reg;
  logic              error_reg;

  logic rx_ready_reg, rx_ready_next;
  logic ram_load_reg, ram_load_next;
  logic busy_reg, busy_next;
  logic done_reg, done_next;

  logic             xfer;
  logic             verify_fail;
  logic [CNT_W-1:0] count_clamped;

  // A byte moves only when the source offers and we are in a byte-collecting state.
  assign xfer = rx_valid && rx_ready_reg;

  // Requests beyond the RAM size are trimmed to one full pass of the RAM.
  assign count_clamped = (word_count > MAX_WORDS) ? MAX_WORDS : word_count;

`ifdef RAM512_LOADER_VERIFY_EN
  // Read-back check: the RAM output reflects the word just written at this address.
  assign verify_fail = (ram_out != data_reg);
`else
  assign verify_fail = 1'b0;
  // Read data is not needed without read-back verification.
  logic unused_ram_out;
  assign unused_ram_out = ^ram_out;
`endif

  // State register together with the registered control outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      rx_ready_reg <= 1'b0;
      ram_load_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      rx_ready_reg <= rx_ready_next;
      ram_load_reg <= ram_load_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  // Next-state logic: collect high byte, low byte, write, optional check, advance.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE: if (start) state_next = (count_clamped == '0) ? ST_FIN : ST_HI;
      ST_HI:   if (xfer) state_next = ST_LO;
      ST_LO:   if (xfer) state_next = ST_WR;
`ifdef RAM512_LOADER_VERIFY_EN
      ST_WR:   state_next = ST_VFY;
      ST_VFY:  state_next = verify_fail ? ST_FIN : ST_ADV;
`else
      ST_WR:   state_next = ST_ADV;
`endif
      ST_ADV:  state_next = (remaining_reg == CNT_ONE) ? ST_FIN : ST_HI;
      ST_FIN:  state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // Output decode from the upcoming state so every output leaves a flop.
  always_comb begin
    rx_ready_next = (state_next == ST_HI) || (state_next == ST_LO);
    ram_load_next = (state_next == ST_WR);
    busy_next     = (state_next != ST_IDLE);
    done_next     = (state_reg == ST_FIN);
  end

  // Datapath: address, word assembly, counters and the sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      remaining_reg     <= '0;
      words_written_reg <= '0;
      addr_reg          <= '0;
      data_reg          <= '0;
      error_reg         <= 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (start) begin
            addr_reg          <= base_addr;
            remaining_reg     <= count_clamped;
            words_written_reg <= '0;
            error_reg         <= 1'b0;
          end
        end
        ST_HI: if (xfer) data_reg[15:8] <= rx_data;
        ST_LO: if (xfer) data_reg[7:0]  <= rx_data;
`ifdef RAM512_LOADER_VERIFY_EN
        ST_VFY: if (verify_fail) error_reg <= 1'b1;
`endif
        ST_ADV: begin
          words_written_reg <= words_written_reg + CNT_ONE;
          remaining_reg     <= remaining_reg - CNT_ONE;
          addr_reg          <= addr_reg + ADDR_ONE;
        end
        default: ;
      endcase
    end
  end

  assign rx_ready      = rx_ready_reg;
  assign ram_in        = data_reg;
  assign ram_address   = addr_reg;
  assign ram_load      = ram_load_reg;
  assign busy          = busy_reg;
  assign done          = done_reg;
  assign error         = error_reg;
  assign words_written = words_written_reg;

endmodule

// File: tb/tb_ram512_loader.sv
// Bench for ram512_loader: drives byte streams into the loader and keeps a
// 512-word RAM model on its write port. Expected writes are derived from the
// byte stream and base address by plain arithmetic.
`timescale 1ns/1ps
module tb_ram512_loader;

`ifdef RAM512_LOADER_VERIFY_EN
  localparam int WORD_CYC = 5;
`else
  localparam int WORD_CYC = 4;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [8:0]  base_addr;
  logic [9:0]  word_count;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [15:0] ram_in;
  logic [8:0]  ram_address;
  logic        ram_load;
  logic [15:0] ram_out;
  logic        busy;
  logic        done;
  logic        error;
  logic [9:0]  words_written;

  always #5 clk = ~clk;

  ram512_loader dut (
    .clk(clk), .rst(rst), .start(start), .base_addr(base_addr),
    .word_count(word_count), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .ram_in(ram_in), .ram_address(ram_address),
    .ram_load(ram_load), .ram_out(ram_out), .busy(busy), .done(done),
    .error(error), .words_written(words_written)
  );

  // RAM model with an optional stuck-at-0 on bit 0 of address 5.
  logic [15:0] mem [0:511];
  bit          stuck5 = 1'b0;
  assign ram_out = mem[ram_address];

  // Byte stream offered to the loader.
  logic [7:0] stim [0:2047];

  // Monitor bookkeeping (written only by the monitor).
  int          cyc = 0, busy_cyc = 0, rdy_cyc = 0, done_cnt = 0;
  int          overlap_cnt = 0, long_cnt = 0, err_cyc = 0, wr_n = 0;
  logic [8:0]  wr_addr [0:4095];
  logic [15:0] wr_data [0:4095];
  int          wr_cyc  [0:4095];
  logic        prev_load = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  // Sample outputs on the falling edge; record writes and update the RAM model.
  always @(negedge clk) begin
    cyc = cyc + 1;
    if (busy === 1'b1) busy_cyc = busy_cyc + 1;
    if (rx_ready === 1'b1) rdy_cyc = rdy_cyc + 1;
    if (done === 1'b1) done_cnt = done_cnt + 1;
    if (error === 1'b1) err_cyc = err_cyc + 1;
    if (rx_ready === 1'b1 && ram_load === 1'b1) overlap_cnt = overlap_cnt + 1;
    if (ram_load === 1'b1 && prev_load === 1'b1) long_cnt = long_cnt + 1;
    if (ram_load === 1'b1) begin
      if (wr_n < 4096) begin
        wr_addr[wr_n] = ram_address;
        wr_data[wr_n] = ram_in;
        wr_cyc[wr_n]  = cyc;
      end
      wr_n = wr_n + 1;
      mem[ram_address] = (stuck5 && ram_address == 9'd5) ? (ram_in & 16'hFFFE) : ram_in;
    end
    prev_load = ram_load;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] exp_word(input int i);
    return {stim[2*i], stim[2*i+1]};
  endfunction

  function automatic logic [8:0] exp_addr(input int base, input int i);
    return 9'((base + i) % 512);
  endfunction

  task automatic check_idle_outputs(input string tag);
    check({tag, "_rx_ready"},      32'(rx_ready),      32'd0);
    check({tag, "_ram_load"},      32'(ram_load),      32'd0);
    check({tag, "_ram_in"},        32'(ram_in),        32'd0);
    check({tag, "_ram_address"},   32'(ram_address),   32'd0);
    check({tag, "_busy"},          32'(busy),          32'd0);
    check({tag, "_done"},          32'(done),          32'd0);
    check({tag, "_error"},         32'(error),         32'd0);
    check({tag, "_words_written"}, 32'(words_written), 32'd0);
  endtask

  // Offer nbytes from stim with an optional gap after each accepted byte and
  // an optional extra start pulse once byte extra_at is next in line.
  task automatic feed(input int nbytes, input int throttle, input int extra_at, output int ok);
    int idx, gap, guard;
    bit extra_sent;
    idx = 0; gap = 0; guard = 0; extra_sent = 1'b0; ok = 1;
    while (idx < nbytes) begin
      @(negedge clk);
      start = 1'b0;
      if (!extra_sent && idx == extra_at) begin
        start = 1'b1; base_addr = 9'd300; word_count = 10'd1; extra_sent = 1'b1;
      end
      if (gap > 0) begin
        rx_valid = 1'b0; gap--;
      end else begin
        rx_valid = 1'b1; rx_data = stim[idx];
      end
      if (rx_valid && rx_ready === 1'b1) begin
        idx++; gap = throttle;
      end
      guard++;
      if (guard > 8000) begin
        ok = 0;
        break;
      end
    end
  endtask

  task automatic wait_done(input string tag);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 3000 && !got; i++) begin
      @(negedge clk);
      start = 1'b0; rx_valid = 1'b0;
      if (done === 1'b1) got = 1'b1;
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    @(negedge clk);
  endtask

  // Full load plus the checks every completed load must satisfy.
  task automatic do_load(input string tag, input int base, input int cnt,
                         input int throttle, input int extra_at);
    int nw, w0, d0, o0, l0, ok, bad;
    nw = (cnt > 512) ? 512 : cnt;
    w0 = wr_n; d0 = done_cnt; o0 = overlap_cnt; l0 = long_cnt;
    @(negedge clk);
    base_addr = 9'(base); word_count = 10'(cnt); start = 1'b1;
    feed(2 * nw, throttle, extra_at, ok);
    check({tag, "_feed_ok"}, 32'(ok), 32'd1);
    wait_done(tag);
    check({tag, "_write_count"}, 32'(wr_n - w0), 32'(nw));
    if (nw <= 8) begin
      for (int i = 0; i < nw && (w0 + i) < wr_n; i++) begin
        check($sformatf("%s_w%0d_addr", tag, i), 32'(wr_addr[w0 + i]), 32'(exp_addr(base, i)));
        check($sformatf("%s_w%0d_data", tag, i), 32'(wr_data[w0 + i]), 32'(exp_word(i)));
      end
    end else begin
      bad = 0;
      for (int i = 0; i < nw && (w0 + i) < wr_n; i++)
        if (wr_addr[w0 + i] !== exp_addr(base, i) || wr_data[w0 + i] !== exp_word(i)) bad++;
      check({tag, "_bulk_writes_bad"}, 32'(bad), 32'd0);
    end
    check({tag, "_words_written"}, 32'(words_written), 32'(nw));
    check({tag, "_busy_after"},    32'(busy),          32'd0);
    check({tag, "_done_pulses"},   32'(done_cnt - d0), 32'd1);
    check({tag, "_rdy_and_load"},  32'(overlap_cnt - o0), 32'd0);
    check({tag, "_load_gt_1cyc"},  32'(long_cnt - l0),    32'd0);
  endtask

  // Watchdog: a hung run still reports.
  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish expected finish before timeout");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int w0, b0, r0, ok, d0;
    int base, cnt, thr;

    rst = 1'b1; start = 1'b0; base_addr = '0; word_count = '0;
    rx_data = '0; rx_valid = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs("reset");
    rst = 1'b0;
    @(negedge clk);

    // Directed load from address 0 with a continuous source.
    stim[0] = 8'h12; stim[1] = 8'h34; stim[2] = 8'hAB;
    stim[3] = 8'hCD; stim[4] = 8'h00; stim[5] = 8'h01;
    w0 = wr_n;
    do_load("basic", 0, 3, 0, -1);
    check("basic_word_spacing", 32'(wr_cyc[w0 + 1] - wr_cyc[w0]), 32'(WORD_CYC));
    check("basic_mem0", 32'(mem[0]), 32'h1234);
    check("basic_mem2", 32'(mem[2]), 32'h0001);

    // Same bytes, throttled source, stray start mid-load, different base.
    do_load("throttle", 100, 3, 3, 3);
    check("throttle_mem100", 32'(mem[100]), 32'h1234);
    check("throttle_mem101", 32'(mem[101]), 32'hABCD);
    check("throttle_mem102", 32'(mem[102]), 32'h0001);

    // Address wrap from 511 to 0.
    stim[0] = 8'h11; stim[1] = 8'h11; stim[2] = 8'h22;
    stim[3] = 8'h22; stim[4] = 8'h33; stim[5] = 8'h33;
    do_load("wrap", 510, 3, 0, -1);
    check("wrap_mem0", 32'(mem[0]), 32'h3333);

    // Zero-length load.
    b0 = busy_cyc; r0 = rdy_cyc;
    do_load("zero", 40, 0, 0, -1);
    check("zero_busy_cycles",  32'(busy_cyc - b0), 32'd1);
    check("zero_rx_ready_cyc", 32'(rdy_cyc - r0),  32'd0);

    // Randomized loads.
    for (int r = 0; r < 4; r++) begin
      base = int'($urandom_range(0, 511));
      cnt  = int'($urandom_range(1, 6));
      thr  = int'($urandom_range(0, 2));
      for (int i = 0; i < 2 * cnt; i++) stim[i] = 8'($urandom);
      do_load($sformatf("rnd%0d", r), base, cnt, thr, -1);
    end

    // Oversized count is trimmed to 512 words.
    for (int i = 0; i < 1024; i++) stim[i] = 8'($urandom);
    do_load("clamp", 7, 700, 0, -1);

    // Reset while waiting for the low byte of the second word.
    for (int i = 0; i < 8; i++) stim[i] = 8'($urandom);
    w0 = wr_n;
    @(negedge clk);
    base_addr = 9'd20; word_count = 10'd4; start = 1'b1;
    feed(3, 0, -1, ok);
    check("rst_feed_ok", 32'(ok), 32'd1);
    @(negedge clk);
    check("rst_pre_rx_ready", 32'(rx_ready), 32'd1);
    check("rst_pre_writes",   32'(wr_n - w0), 32'd1);
    rst = 1'b1; rx_valid = 1'b0; start = 1'b0;
    @(negedge clk);
    check_idle_outputs("rst_mid");
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      rx_valid = 1'b1; rx_data = 8'($urandom);
    end
    @(negedge clk);
    rx_valid = 1'b0;
    @(negedge clk);
    check("rst_post_writes", 32'(wr_n - w0), 32'd1);
    check("rst_mem20",       32'(mem[20]), 32'(exp_word(0)));

`ifdef RAM512_LOADER_VERIFY_EN
    // Read-back mismatch aborts the load and raises a sticky error.
    stuck5 = 1'b1;
    for (int i = 0; i < 4; i++) stim[i] = 8'hFF;
    w0 = wr_n; d0 = done_cnt;
    @(negedge clk);
    base_addr = 9'd5; word_count = 10'd2; start = 1'b1;
    feed(2, 0, -1, ok);
    check("vfy_feed_ok", 32'(ok), 32'd1);
    wait_done("vfy");
    check("vfy_error",         32'(error),         32'd1);
    check("vfy_words_written", 32'(words_written), 32'd0);
    check("vfy_done_pulses",   32'(done_cnt - d0), 32'd1);
    check("vfy_writes",        32'(wr_n - w0),     32'd1);
    check("vfy_busy_after",    32'(busy),          32'd0);
    stuck5 = 1'b0;
    @(negedge clk);
    base_addr = 9'd6; word_count = 10'd0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("vfy_error_cleared", 32'(error), 32'd0);
    check("vfy_restart_busy",  32'(busy),  32'd1);
    wait_done("vfy_restart");
`else
    check("no_vfy_error_never_set", 32'(err_cyc), 32'd0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
